// File: rtl/y86_pkg.sv
// Shared y86 definitions: register index encodings, word width and index helpers.
package y86_pkg;

    localparam int unsigned WORD_W = 64;

    typedef logic [3:0] reg_idx_t;

    localparam reg_idx_t RRAX  = 4'd0;
    localparam reg_idx_t RRCX  = 4'd1;
    localparam reg_idx_t RRDX  = 4'd2;
    localparam reg_idx_t RRBX  = 4'd3;
    localparam reg_idx_t RRSP  = 4'd4;
    localparam reg_idx_t RRBP  = 4'd5;
    localparam reg_idx_t RRSI  = 4'd6;
    localparam reg_idx_t RRDI  = 4'd7;
    localparam reg_idx_t R8    = 4'd8;
    localparam reg_idx_t R9    = 4'd9;
    localparam reg_idx_t R10   = 4'd10;
    localparam reg_idx_t R11   = 4'd11;
    localparam reg_idx_t R12   = 4'd12;
    localparam reg_idx_t R13   = 4'd13;
    localparam reg_idx_t R14   = 4'd14;
    localparam reg_idx_t RNONE = 4'hF;

    // An index names real storage only if it is not RNONE and lies below the register count.
    function automatic logic idx_valid(reg_idx_t idx, int unsigned nreg);
        return (idx != RNONE) && (32'(idx) < nreg);
    endfunction

endpackage

// File: rtl/reg_file_param_rdport.sv
// One register-file read port: index check, E-then-M write bypass, optional output register.
module reg_file_rdport
    import y86_pkg::*;
#(
    parameter int unsigned WIDTH    = WORD_W,
    parameter int unsigned NREG     = 15,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned READ_LAT = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_we,
    input  reg_idx_t                   i_src,
    input  reg_idx_t                   i_dstE,
    input  reg_idx_t                   i_dstM,
    input  logic [WIDTH-1:0]           i_valE,
    input  logic [WIDTH-1:0]           i_valM,
    input  logic [NREG-1:0][WIDTH-1:0] i_regs,
    output logic [WIDTH-1:0]           o_val
);

    logic [WIDTH-1:0] w_rd;
    logic [WIDTH-1:0] r_val;

    // A valid src equal to dstE/dstM implies that destination is valid too.
    always_comb begin
        w_rd = '0;
        if (idx_valid(i_src, NREG)) begin
            if ((BYPASS != 0) && i_we && (i_src == i_dstE)) begin
                w_rd = i_valE;
            end else if ((BYPASS != 0) && i_we && (i_src == i_dstM)) begin
                w_rd = i_valM;
            end else begin
                w_rd = i_regs[i_src];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_val <= '0;
        end else begin
            r_val <= w_rd;
        end
    end

    assign o_val = (READ_LAT != 0) ? r_val : w_rd;

endmodule

// File: rtl/reg_file_param.sv
// Decode-stage register file: two write ports (E over M), two read ports with optional bypass/latency.
module reg_file_param
    import y86_pkg::*;
#(
    parameter int unsigned      WIDTH    = WORD_W,
    parameter int unsigned      NREG     = 15,
    parameter int unsigned      SP_IDX   = 4,
    parameter logic [WIDTH-1:0] SP_INIT  = '0,
    parameter int unsigned      BYPASS   = 1,
    parameter int unsigned      READ_LAT = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  reg_idx_t         srcA,
    input  reg_idx_t         srcB,
    input  reg_idx_t         dstE,
    input  reg_idx_t         dstM,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    output logic             wr_conflict
);

    logic [NREG-1:0][WIDTH-1:0] r_regs;

    // Port E is written after port M so its update wins when both name the same register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (we) begin
            if (idx_valid(dstM, NREG)) begin
                r_regs[dstM] <= valM;
            end
            if (idx_valid(dstE, NREG)) begin
                r_regs[dstE] <= valE;
            end
        end
    end

    assign wr_conflict = we && (dstE == dstM) && idx_valid(dstE, NREG);

    reg_file_rdport #(
        .WIDTH    (WIDTH),
        .NREG     (NREG),
        .BYPASS   (BYPASS),
        .READ_LAT (READ_LAT)
    ) u_rd_a (
        .i_clk  (clock),
        .i_rst  (reset),
        .i_we   (we),
        .i_src  (srcA),
        .i_dstE (dstE),
        .i_dstM (dstM),
        .i_valE (valE),
        .i_valM (valM),
        .i_regs (r_regs),
        .o_val  (valA)
    );

    reg_file_rdport #(
        .WIDTH    (WIDTH),
        .NREG     (NREG),
        .BYPASS   (BYPASS),
        .READ_LAT (READ_LAT)
    ) u_rd_b (
        .i_clk  (clock),
        .i_rst  (reset),
        .i_we   (we),
        .i_src  (srcB),
        .i_dstE (dstE),
        .i_dstM (dstM),
        .i_valE (valE),
        .i_valM (valM),
        .i_regs (r_regs),
        .o_val  (valB)
    );

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the decode-stage register file: two write ports (E, M) and two read ports (A, B).
- Width, register count, stack-pointer reset value, same-cycle write-to-read bypass and read latency are all configurable.
- Sits in DECODE, between the decode logic (srcA/srcB) and the writeback stage (dstE/dstM, valE/valM).
- Serves both the sequential and the pipelined y86 cores.

Parameters:
- WIDTH, 64, data width of each register and value port
- NREG, 15, number of architectural registers; valid indices are 0..NREG-1, max 15
- SP_IDX, 4, index of %rsp
- SP_INIT, 0, reset value loaded into register SP_IDX
- BYPASS, 1, 1 = a read of a register being written this cycle returns the incoming value
- READ_LAT, 0, 0 = combinational read; 1 = read data registered on posedge clock

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- we  in  1  global write enable; 0 = stall/bubble, no writes
- srcA  in  4  read port A index; 4'hF = none
- srcB  in  4  read port B index; 4'hF = none
- dstE  in  4  write port E index; 4'hF = none
- dstM  in  4  write port M index; 4'hF = none
- valE  in  WIDTH  write data, port E
- valM  in  WIDTH  write data, port M
- valA  out  WIDTH  read data, port A
- valB  out  WIDTH  read data, port B
- wr_conflict  out  1  dstE and dstM name the same valid register with we=1

Behaviour:
- Reset (asynchronous, any time including mid-write):
  - All registers go to 0, except register SP_IDX, which goes to SP_INIT.
  - When READ_LAT=1, the valA/valB output registers go to 0.
  - A write coincident with reset is discarded.
- Write, on posedge clock when reset=0 and we=1:
  - Port M writes valM to reg[dstM] if dstM != 4'hF and dstM < NREG.
  - Port E writes valE to reg[dstE] under the same rule.
  - An index of 4'hF, or one >= NREG, is ignored silently; no state changes.
  - If dstE == dstM (and valid), valE wins and valM is dropped. This is the fixed priority.
- Read value for src (combinational term):
  - src == 4'hF or src >= NREG gives 0.
  - Else, if BYPASS=1, we=1 and src == dstE (valid), the value is valE.
  - Else, if BYPASS=1, we=1 and src == dstM (valid), the value is valM.
  - Else the value is reg[src].
  - The E-before-M ordering matches write priority.
- Latency:
  - READ_LAT=0: valA/valB are the combinational term, with zero cycle latency.
  - READ_LAT=1: valA/valB capture the combinational term on posedge, giving one cycle latency. With BYPASS=1, a same-cycle write is reflected in the captured value.
- BYPASS=0: a read of a register written this cycle returns the old value. The new value is visible the next cycle (READ_LAT=0) or after the next capture.
- we=0: no register changes. Reads continue, and bypass is disabled.
- wr_conflict is combinational: we & (dstE==dstM) & (dstE != 4'hF) & (dstE < NREG). It is informational only and does not alter the write.
- Reads and writes with both ports at 4'hF: outputs 0 and no state change. This is the legal idle state.
- No X on any output after reset. Register contents persist indefinitely without writes.

Decomposition:
- Shared package y86_pkg:
  - RNONE = 4'hF
  - register index constants (RRAX=0 ... RRSP=4 ... R14=14)
  - WORD_W = 64
  - reg_idx_t (4-bit) typedef
- One sub-module, reg_file_rdport: one read-port mux (index check, bypass select, optional output register). It is instantiated twice, for A and B.
- The storage array and write logic stay in the top.

Test Plan:
- Reset with SP_INIT=64'h100, then read srcA=4, srcB=0 -> valA=64'h100, valB=0. All 15 registers read back 0 except index 4.
- we=1, dstE=2, valE=64'hDEAD, srcA=2, BYPASS=1, READ_LAT=0:
  - Same cycle, valA=64'hDEAD.
  - With BYPASS=0, the same cycle gives valA=0 and the next cycle gives valA=64'hDEAD.
- dstE=dstM=3, valE=64'h11, valM=64'h22, we=1 -> wr_conflict=1 that cycle. reg[3] reads 64'h11 afterwards.
- we=0, dstE=5, valE=64'hFF -> reg[5] is unchanged (0) and wr_conflict=0. srcB=4'hF -> valB=0. dstM=4'hE with NREG=14 -> ignored.
- READ_LAT=1: write reg[7]=64'h77, then set srcA=7 -> valA changes exactly one posedge later. Assert reset mid-sequence -> valA=0 immediately, and reg[7] reads 0 after release.
